// File: rtl/keypad_pkg.sv
// Shared types and the key legend for the keypad debounce/decode path.
// Index convention everywhere: {row_idx, col_idx}, where index 0 is the top row / left column.
package keypad_pkg;

  typedef enum logic [1:0] {
    NONE,
    SINGLE,
    INVALID
  } frame_kind_e;

  typedef enum logic [1:0] {
    IDLE,
    DEBOUNCE,
    HELD,
    RELEASE
  } kd_state_e;

  // Rows top to bottom: 1 2 3 A / 4 5 6 B / 7 8 9 C / E 0 F D
  localparam logic [3:0] KEY_LUT [16] = '{
    4'h1, 4'h2, 4'h3, 4'hA,
    4'h4, 4'h5, 4'h6, 4'hB,
    4'h7, 4'h8, 4'h9, 4'hC,
    4'hE, 4'h0, 4'hF, 4'hD
  };

  // Bit 3 is position 0; the caller guarantees v is one-hot.
  function automatic logic [1:0] onehot_to_idx(input logic [3:0] v);
    case (v)
      4'b1000: return 2'd0;
      4'b0100: return 2'd1;
      4'b0010: return 2'd2;
      default: return 2'd3;
    endcase
  endfunction

endpackage

// File: rtl/key_debounce_decode_if.sv
// Decoded-key channel from the debouncer to the display/entry logic.
// valid/ready: the master raises key_valid with key_code and holds both steady until a
// cycle where key_valid & key_ready are high; that cycle is the transfer.
interface key_debounce_decode_if;
  logic [3:0] key_code;
  logic       key_valid;
  logic       key_ready;

  modport master (output key_code, output key_valid, input key_ready);
  modport slave  (input key_code, input key_valid, output key_ready);
endinterface

// File: rtl/kp_frame_collector.sv
// Reduces each 4-cycle scan frame (ending on column 4'b0001) to NONE / SINGLE(idx) / INVALID,
// presented one cycle after the frame-end cycle together with a frame_done strobe.
module kp_frame_collector
  import keypad_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic [7:0]  rcbits,
  output logic        frame_done,
  output frame_kind_e frame_kind,
  output logic [3:0]  frame_idx
);

  logic [3:0] row;
  logic [3:0] col;
  logic       frame_end;
  logic [1:0] hits_q, hits_d;
  logic [3:0] idx_q, idx_d;
  logic       bad_q, bad_d;
  logic       synced_q;

  assign row       = rcbits[7:4];
  assign col       = rcbits[3:0];
  assign frame_end = (col == 4'b0001);

  // Accumulator including the current cycle, so the frame-end cycle counts.
  always_comb begin
    hits_d = hits_q;
    idx_d  = idx_q;
    bad_d  = bad_q | ~$onehot(col);
    if ($countones(row) > 1) begin
      hits_d = 2'd2;
    end else if ($countones(row) == 1) begin
      idx_d  = {onehot_to_idx(row), onehot_to_idx(col)};
      hits_d = (hits_q == 2'd0) ? 2'd1 : 2'd2;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      hits_q     <= 2'd0;
      idx_q      <= 4'd0;
      bad_q      <= 1'b0;
      synced_q   <= 1'b0;
      frame_done <= 1'b0;
      frame_kind <= NONE;
      frame_idx  <= 4'd0;
    end else begin
      frame_done <= frame_end;
      if (frame_end) begin
        hits_q    <= 2'd0;
        idx_q     <= 4'd0;
        bad_q     <= 1'b0;
        synced_q  <= 1'b1;
        frame_idx <= idx_d;
        // The first frame after reset may have started before reset released.
        if (!synced_q || bad_d || hits_d == 2'd2) frame_kind <= INVALID;
        else if (hits_d == 2'd1)                  frame_kind <= SINGLE;
        else                                      frame_kind <= NONE;
      end else begin
        hits_q <= hits_d;
        idx_q  <= idx_d;
        bad_q  <= bad_d;
      end
    end
  end

endmodule

// File: rtl/key_debounce_decode.sv
// Debounces per-frame keypad results, decodes the accepted key to a hex digit and offers it on
// a valid/ready channel; a new press while a key is still pending raises a one-cycle overrun.
module key_debounce_decode
  import keypad_pkg::*;
#(
  parameter int DEBOUNCE_FRAMES = 4,
  parameter int RELEASE_FRAMES  = 4
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic [7:0]                   rcbits,
  key_debounce_decode_if.master        key_if,
  output logic                         key_held,
  output logic                         overrun,
  output kd_state_e                    state_dbg
);

  localparam int CW = $clog2(DEBOUNCE_FRAMES + 1);
  localparam int RW = $clog2(RELEASE_FRAMES + 1);

  logic        frame_done;
  frame_kind_e frame_kind;
  logic [3:0]  frame_idx;

  kd_state_e     state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [RW-1:0] rcnt_q, rcnt_d;
  logic [3:0]    cand_q, cand_d;
  logic [3:0]    code_q, code_d;
  logic          valid_q, valid_d;
  logic          overrun_q, overrun_d;
  logic          accept;
  logic          handshake;

  kp_frame_collector u_collector (
    .clk        (clk),
    .reset      (reset),
    .rcbits     (rcbits),
    .frame_done (frame_done),
    .frame_kind (frame_kind),
    .frame_idx  (frame_idx)
  );

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    rcnt_d  = rcnt_q;
    cand_d  = cand_q;
    accept  = 1'b0;
    if (frame_done) begin
      case (state_q)
        IDLE: begin
          if (frame_kind == SINGLE) begin
            cand_d = frame_idx;
            if (DEBOUNCE_FRAMES == 1) begin
              accept  = 1'b1;
              state_d = HELD;
              cnt_d   = '0;
            end else begin
              state_d = DEBOUNCE;
              cnt_d   = CW'(1);
            end
          end
        end
        DEBOUNCE: begin
          if (frame_kind == SINGLE && frame_idx == cand_q) begin
            if (int'(cnt_q) + 1 >= DEBOUNCE_FRAMES) begin
              accept  = 1'b1;
              state_d = HELD;
              cnt_d   = '0;
            end else begin
              cnt_d = cnt_q + 1'b1;
            end
          end else if (frame_kind == SINGLE) begin
            cand_d = frame_idx;
            cnt_d  = CW'(1);
          end else begin
            state_d = IDLE;
            cnt_d   = '0;
          end
        end
        HELD: begin
          // No rollover: any non-empty frame keeps the current key held.
          if (frame_kind == NONE) begin
            if (RELEASE_FRAMES == 1) begin
              state_d = IDLE;
            end else begin
              state_d = RELEASE;
              rcnt_d  = RW'(1);
            end
          end
        end
        RELEASE: begin
          if (frame_kind == NONE) begin
            if (int'(rcnt_q) + 1 >= RELEASE_FRAMES) begin
              state_d = IDLE;
              rcnt_d  = '0;
            end else begin
              rcnt_d = rcnt_q + 1'b1;
            end
          end else begin
            state_d = HELD;
            rcnt_d  = '0;
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  // A transfer in the same cycle as an accept frees the slot before the new key loads.
  always_comb begin
    handshake = valid_q & key_if.key_ready;
    code_d    = code_q;
    valid_d   = valid_q & ~handshake;
    overrun_d = 1'b0;
    if (accept) begin
      if (valid_d) begin
        overrun_d = 1'b1;
      end else begin
        code_d  = KEY_LUT[cand_d];
        valid_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      rcnt_q    <= '0;
      cand_q    <= 4'd0;
      code_q    <= 4'd0;
      valid_q   <= 1'b0;
      overrun_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      rcnt_q    <= rcnt_d;
      cand_q    <= cand_d;
      code_q    <= code_d;
      valid_q   <= valid_d;
      overrun_q <= overrun_d;
    end
  end

  assign key_if.key_code  = code_q;
  assign key_if.key_valid = valid_q;
  assign key_held         = (state_q == HELD) || (state_q == RELEASE);
  assign overrun          = overrun_q;
  assign state_dbg        = state_q;

endmodule

// File: tb/tb_key_debounce_decode.sv
// Frame-level bench for key_debounce_decode: each scan frame is driven as 4 cycles and the
// outputs seen right after that frame's decision edge are compared against a press/release model.
`timescale 1ns/1ps
module tb_key_debounce_decode;
  import keypad_pkg::*;

  localparam int DEB      = 4;
  localparam int REL      = 4;
  localparam int K_NONE   = 0;
  localparam int K_SINGLE = 1;
  localparam int K_MULTI  = 2;
  localparam int K_BADCOL = 3;

  logic      clk = 1'b0;
  logic      reset = 1'b1;
  logic [7:0] rcbits = 8'h00;
  logic      key_held;
  logic      overrun;
  kd_state_e state_dbg;

  key_debounce_decode_if key_if ();

  key_debounce_decode #(.DEBOUNCE_FRAMES(DEB), .RELEASE_FRAMES(REL)) dut (
    .clk       (clk),
    .reset     (reset),
    .rcbits    (rcbits),
    .key_if    (key_if),
    .key_held  (key_held),
    .overrun   (overrun),
    .state_dbg (state_dbg)
  );

  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;

  // Reference model: press/release bookkeeping in frame units
  logic [3:0] ref_lut [16];
  bit         m_armed, m_pending, m_skip, m_have_last;
  int         m_streak, m_empty, m_last_kind;
  logic [3:0] m_cand, m_code, m_last_idx;
  int         exp_ovr_total = 0;
  int         ovr_seen = 0;
  logic [7:0] exp_vec, obs_vec;
  logic       obs_valid, obs_held, obs_ovr;
  logic [3:0] obs_code;
  kd_state_e  obs_state;

  always @(negedge clk) if (overrun === 1'b1) ovr_seen++;

  task automatic model_reset();
    m_armed = 1; m_pending = 0; m_skip = 1; m_have_last = 0;
    m_streak = 0; m_empty = 0; m_last_kind = K_NONE;
    m_cand = 4'h0; m_code = 4'h0; m_last_idx = 4'h0;
  endtask

  // Drives one frame (from cycle first_c) with key_ready=rdy for the whole frame.
  task automatic send_frame(input int kind, input logic [3:0] idx, input logic rdy,
                            input int first_c = 0);
    bit press;
    bit e_ovr;
    logic [3:0] col, row;
    press = 0;
    e_ovr = 0;
    if (m_have_last) begin
      if (m_armed) begin
        if (m_last_kind == K_SINGLE) begin
          m_streak = (m_streak > 0 && m_last_idx == m_cand) ? m_streak + 1 : 1;
          m_cand   = m_last_idx;
          if (m_streak == DEB) begin
            press = 1; m_armed = 0; m_empty = 0; m_streak = 0;
          end
        end else begin
          m_streak = 0;
        end
      end else if (m_last_kind == K_NONE) begin
        m_empty++;
        if (m_empty == REL) begin m_armed = 1; m_empty = 0; end
      end else begin
        m_empty = 0;
      end
    end
    if (press) begin
      if (m_pending && !rdy) begin
        e_ovr = 1; exp_ovr_total++;
      end else begin
        m_pending = 1; m_code = ref_lut[m_cand];
      end
    end else if (rdy) begin
      m_pending = 0;
    end
    exp_vec = {m_pending, !m_armed, e_ovr, 1'b0, m_pending ? m_code : 4'h0};
    for (int c = first_c; c < 4; c++) begin
      @(negedge clk);
      if (c == first_c + 1) begin
        obs_valid = key_if.key_valid; obs_code = key_if.key_code;
        obs_held  = key_held; obs_ovr = overrun; obs_state = state_dbg;
        obs_vec   = {obs_valid, obs_held, obs_ovr, 1'b0, obs_valid ? obs_code : 4'h0};
      end
      col = 4'b1000 >> c;
      row = 4'b0000;
      if ((kind == K_SINGLE || kind == K_BADCOL) && idx[1:0] == c[1:0]) row = 4'b1000 >> idx[3:2];
      if (kind == K_MULTI && c == 0) row = 4'b1100;
      if (kind == K_BADCOL && c == 2) begin col = 4'b0011; row = 4'b0000; end
      rcbits = {row, col};
      key_if.key_ready = rdy;
    end
    if (rdy) m_pending = 0;
    if (m_skip || kind == K_MULTI || kind == K_BADCOL) m_last_kind = K_MULTI;
    else m_last_kind = kind;
    m_last_idx  = idx;
    m_skip      = 0;
    m_have_last = 1;
  endtask

  task automatic test_reset();
    reset = 1'b1; rcbits = 8'h00; key_if.key_ready = 1'b0;
    repeat (3) @(negedge clk);
    checks += 5;
    if (key_if.key_valid !== 1'b0) begin failures++; $display("FAIL reset_valid got=%b want=0", key_if.key_valid); end
    if (key_if.key_code !== 4'h0) begin failures++; $display("FAIL reset_code got=%h want=0", key_if.key_code); end
    if (key_held !== 1'b0) begin failures++; $display("FAIL reset_held got=%b want=0", key_held); end
    if (overrun !== 1'b0) begin failures++; $display("FAIL reset_overrun got=%b want=0", overrun); end
    if (state_dbg !== IDLE) begin failures++; $display("FAIL reset_state got=%0d want=%0d", state_dbg, IDLE); end
    reset = 1'b0;
    model_reset();
    // Absorb the discarded first frame.
    send_frame(K_NONE, 4'h0, 1'b0);
  endtask

  task automatic test_basic_press();
    for (int f = 0; f < 10; f++) begin
      send_frame(f < 5 ? K_SINGLE : K_NONE, 4'h0, f >= 5);
      checks++;
      if (obs_vec !== exp_vec) begin failures++; $display("FAIL basic f%0d got=%b want=%b", f, obs_vec, exp_vec); end
      if (f == 4) begin
        checks++;
        if (obs_valid !== 1'b1 || obs_code !== 4'h1 || obs_held !== 1'b1) begin
          failures++; $display("FAIL basic_key1 got v=%b c=%h h=%b want v=1 c=1 h=1", obs_valid, obs_code, obs_held);
        end
      end
    end
  endtask

  task automatic test_interrupted();
    int rises, first_rise;
    logic prev_v;
    rises = 0; first_rise = -1; prev_v = 0;
    for (int f = 0; f < 9; f++) begin
      send_frame(f == 3 ? K_NONE : K_SINGLE, 4'h6, 1'b0);
      checks++;
      if (obs_vec !== exp_vec) begin failures++; $display("FAIL interrupted f%0d got=%b want=%b", f, obs_vec, exp_vec); end
      if (obs_valid && !prev_v) begin rises++; if (first_rise < 0) first_rise = f; end
      prev_v = obs_valid;
    end
    checks++;
    if (rises != 1 || first_rise != 8) begin
      failures++; $display("FAIL interrupted_once got rises=%0d at=%0d want rises=1 at=8", rises, first_rise);
    end
    for (int f = 0; f < 5; f++) begin
      send_frame(K_NONE, 4'h0, 1'b1);
      checks++;
      if (obs_vec !== exp_vec) begin failures++; $display("FAIL interrupted_rel f%0d got=%b want=%b", f, obs_vec, exp_vec); end
    end
  endtask

  task automatic test_switch();
    int bad_codes;
    bad_codes = 0;
    for (int f = 0; f < 7; f++) begin
      send_frame(K_SINGLE, f < 2 ? 4'b0111 : 4'b1101, 1'b0);
      checks++;
      if (obs_vec !== exp_vec) begin failures++; $display("FAIL switch f%0d got=%b want=%b", f, obs_vec, exp_vec); end
      if (obs_valid && obs_code !== 4'h0) bad_codes++;
    end
    checks++;
    if (bad_codes != 0 || obs_valid !== 1'b1 || obs_code !== 4'h0) begin
      failures++; $display("FAIL switch_code got v=%b c=%h others=%0d want v=1 c=0 others=0", obs_valid, obs_code, bad_codes);
    end
    for (int f = 0; f < 5; f++) begin
      send_frame(K_NONE, 4'h0, 1'b1);
      checks++;
      if (obs_vec !== exp_vec) begin failures++; $display("FAIL switch_rel f%0d got=%b want=%b", f, obs_vec, exp_vec); end
    end
  endtask

  task automatic test_invalid();
    for (int f = 0; f < 12; f++) begin
      send_frame(f < 6 ? K_MULTI : K_BADCOL, 4'h0, 1'b0);
      checks++;
      if (obs_vec !== exp_vec) begin failures++; $display("FAIL invalid f%0d got=%b want=%b", f, obs_vec, exp_vec); end
      if (f >= 1) begin
        checks++;
        if (obs_state !== IDLE || obs_valid !== 1'b0) begin
          failures++; $display("FAIL invalid_idle f%0d got state=%0d v=%b want state=%0d v=0", f, obs_state, obs_valid, IDLE);
        end
      end
    end
  endtask

  task automatic test_overrun();
    int ovr_before;
    ovr_before = ovr_seen;
    for (int f = 0; f < 13; f++) begin
      send_frame((f < 4) ? K_SINGLE : (f < 8) ? K_NONE : K_SINGLE, (f < 4) ? 4'b0101 : 4'b1010, 1'b0);
      checks++;
      if (obs_vec !== exp_vec) begin failures++; $display("FAIL overrun f%0d got=%b want=%b", f, obs_vec, exp_vec); end
    end
    checks++;
    if (ovr_seen - ovr_before != 1 || obs_ovr !== 1'b1 || obs_code !== 4'h5 || obs_valid !== 1'b1) begin
      failures++; $display("FAIL overrun_pulse got n=%0d ovr=%b c=%h want n=1 ovr=1 c=5", ovr_seen - ovr_before, obs_ovr, obs_code);
    end
    send_frame(K_SINGLE, 4'b1010, 1'b1);
    checks++;
    if (obs_valid !== 1'b0) begin failures++; $display("FAIL overrun_ready got v=%b want v=0", obs_valid); end
    for (int f = 0; f < 5; f++) begin
      send_frame(K_NONE, 4'h0, 1'b1);
      checks++;
      if (obs_vec !== exp_vec) begin failures++; $display("FAIL overrun_rel f%0d got=%b want=%b", f, obs_vec, exp_vec); end
    end
  endtask

  task automatic test_same_cycle();
    for (int f = 0; f < 13; f++) begin
      send_frame((f < 4) ? K_SINGLE : (f < 8) ? K_NONE : K_SINGLE, (f < 4) ? 4'b0001 : 4'b1000, f == 12);
      checks++;
      if (obs_vec !== exp_vec) begin failures++; $display("FAIL same_cycle f%0d got=%b want=%b", f, obs_vec, exp_vec); end
    end
    checks++;
    if (obs_valid !== 1'b1 || obs_code !== 4'h7 || obs_ovr !== 1'b0) begin
      failures++; $display("FAIL same_cycle_load got v=%b c=%h ovr=%b want v=1 c=7 ovr=0", obs_valid, obs_code, obs_ovr);
    end
    for (int f = 0; f < 5; f++) begin
      send_frame(K_NONE, 4'h0, 1'b1);
      checks++;
      if (obs_vec !== exp_vec) begin failures++; $display("FAIL same_cycle_rel f%0d got=%b want=%b", f, obs_vec, exp_vec); end
    end
  endtask

  task automatic test_release_bounce();
    for (int f = 0; f < 11; f++) begin
      send_frame((f < 4 || f == 5) ? K_SINGLE : K_NONE, 4'hF, f == 4);
      checks++;
      if (obs_vec !== exp_vec) begin failures++; $display("FAIL bounce f%0d got=%b want=%b", f, obs_vec, exp_vec); end
      if (f == 9 || f == 10) begin
        checks++;
        if (obs_held !== (f == 9)) begin failures++; $display("FAIL bounce_held f%0d got=%b want=%b", f, obs_held, f == 9); end
      end
    end
  endtask

  task automatic test_reset_mid();
    for (int f = 0; f < 10; f++) begin
      send_frame(f < 4 ? K_SINGLE : f < 8 ? K_NONE : K_SINGLE, f < 4 ? 4'b0010 : 4'b0100, 1'b0);
      checks++;
      if (obs_vec !== exp_vec) begin failures++; $display("FAIL reset_mid f%0d got=%b want=%b", f, obs_vec, exp_vec); end
    end
    @(negedge clk) rcbits = {4'b0100, 4'b1000};
    @(negedge clk) rcbits = {4'b0000, 4'b0100};
    @(negedge clk) reset = 1'b1;
    @(negedge clk);
    checks++;
    if (key_if.key_valid !== 1'b0 || key_if.key_code !== 4'h0 || key_held !== 1'b0 || overrun !== 1'b0 || state_dbg !== IDLE) begin
      failures++; $display("FAIL reset_mid_clear got v=%b c=%h h=%b o=%b s=%0d want all 0", key_if.key_valid, key_if.key_code, key_held, overrun, state_dbg);
    end
    reset = 1'b0;
    model_reset();
    send_frame(K_SINGLE, 4'b0100, 1'b0, 2);
    for (int f = 0; f < 5; f++) begin
      send_frame(K_SINGLE, 4'b0100, 1'b0);
      checks++;
      if (obs_vec !== exp_vec) begin failures++; $display("FAIL reset_mid_press f%0d got=%b want=%b", f, obs_vec, exp_vec); end
      checks++;
      if (obs_valid !== (f == 4)) begin failures++; $display("FAIL reset_mid_latency f%0d got=%b want=%b", f, obs_valid, f == 4); end
    end
    checks++;
    if (obs_code !== 4'h4) begin failures++; $display("FAIL reset_mid_code got=%h want=4", obs_code); end
    for (int f = 0; f < 5; f++) begin
      send_frame(K_NONE, 4'h0, 1'b1);
      checks++;
      if (obs_vec !== exp_vec) begin failures++; $display("FAIL reset_mid_rel f%0d got=%b want=%b", f, obs_vec, exp_vec); end
    end
  endtask

  task automatic test_random();
    int sel, kind, len;
    logic [3:0] idx;
    for (int r = 0; r < 60; r++) begin
      sel  = $urandom_range(0, 9);
      kind = (sel < 4) ? K_NONE : (sel < 8) ? K_SINGLE : (sel == 8) ? K_MULTI : K_BADCOL;
      idx  = 4'($urandom_range(0, 15));
      len  = $urandom_range(1, 6);
      for (int j = 0; j < len; j++) begin
        send_frame(kind, idx, $urandom_range(0, 3) == 0);
        checks++;
        if (obs_vec !== exp_vec) begin failures++; $display("FAIL random r%0d j%0d got=%b want=%b", r, j, obs_vec, exp_vec); end
      end
    end
    checks++;
    if (ovr_seen != exp_ovr_total) begin failures++; $display("FAIL overrun_total got=%0d want=%0d", ovr_seen, exp_ovr_total); end
  endtask

  initial begin
    ref_lut = '{4'h1, 4'h2, 4'h3, 4'hA, 4'h4, 4'h5, 4'h6, 4'hB,
                4'h7, 4'h8, 4'h9, 4'hC, 4'hE, 4'h0, 4'hF, 4'hD};
    key_if.key_ready = 1'b0;
    model_reset();
    test_reset();
    test_basic_press();
    test_interrupted();
    test_switch();
    test_invalid();
    test_overrun();
    test_same_cycle();
    test_release_bounce();
    test_reset_mid();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
